// File: rtl/tiny_dnn_out_ctl_if.sv
// Output word stream: valid/ready handshake carrying the result word and its address.
interface tiny_dnn_out_ctl_if;
    logic        ovalid;
    logic [15:0] odata;
    logic [11:0] oa;
    logic        oready;

    modport master (output ovalid, output odata, output oa, input oready);
    modport slave  (input ovalid, input odata, input oa, output oready);
endinterface

// File: rtl/tiny_dnn_out_ctl.sv
// Output controller: 4-deep result FIFO, ovalid one cycle after k_fin, ovf/out_busy/outrf status, oa address walk.
// Optional macro TINY_DNN_OUT_RELU_EN clamps negative forward-pass results to zero before storage.
module tiny_dnn_out_ctl (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_init,
    input  logic                backprop,
    input  logic                k_fin,
    input  logic [15:0]         acc,
    input  logic [3:0]          od,
    input  logic [4:0]          oh,
    input  logic [4:0]          ow,
    input  logic [9:0]          os,
    tiny_dnn_out_ctl_if.master  out_if,
    output logic                out_busy,
    output logic                outrf,
    output logic                ovf
);
    localparam int DEPTH = 4;

    logic [2:0]  count_q, count_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]  ox_q, ox_d;
    logic [4:0]  oy_q, oy_d;
    logic [3:0]  oc_q, oc_d;
    logic        outrf_q, outrf_d;
    logic        ovf_q, ovf_d;
    logic [15:0] mem_q [DEPTH];

    logic        full;
    logic        pop;
    logic        push;
    logic        last_word;
    logic [15:0] push_dat;

    assign full      = (count_q == 3'd4);
    assign pop       = out_if.ovalid && out_if.oready;
    assign push      = k_fin && (!full || pop);
    assign last_word = (ox_q == ow) && (oy_q == oh) && (oc_q == od);

`ifdef TINY_DNN_OUT_RELU_EN
    assign push_dat = (!backprop && acc[15]) ? 16'h0000 : acc;
`else
    logic unused_backprop;
    assign unused_backprop = backprop;
    assign push_dat        = acc;
`endif

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        oc_d     = oc_q;
        outrf_d  = outrf_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;

        if (push && !pop)      count_d = count_q + 3'd1;
        else if (pop && !push) count_d = count_q - 3'd1;

        if (k_fin && full && !pop) ovf_d = 1'b1;

        // Once the final word has gone out the address walk freezes at its terminal point.
        if (pop && !outrf_q) begin
            if (last_word) begin
                outrf_d = 1'b1;
            end else if (ox_q != ow) begin
                ox_d = ox_q + 5'd1;
            end else begin
                ox_d = 5'd0;
                if (oy_q != oh) begin
                    oy_d = oy_q + 5'd1;
                end else begin
                    oy_d = 5'd0;
                    oc_d = oc_q + 4'd1;
                end
            end
        end

        if (s_init) begin
            count_d  = 3'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            ox_d     = 5'd0;
            oy_d     = 5'd0;
            oc_d     = 4'd0;
            outrf_d  = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            ox_q     <= 5'd0;
            oy_q     <= 5'd0;
            oc_q     <= 4'd0;
            outrf_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            oc_q     <= oc_d;
            outrf_q  <= outrf_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; a push while full-and-popping reuses the slot being vacated.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign out_if.ovalid = (count_q != 3'd0);
    assign out_if.odata  = mem_q[rd_ptr_q];
    assign out_if.oa     = 12'(oc_q) * 12'(os)
                         + 12'(oy_q) * (12'(ow) + 12'd1)
                         + 12'(ox_q);

    assign out_busy = (count_q >= 3'd3);
    assign outrf    = outrf_q;
    assign ovf      = ovf_q;
endmodule

// File: doc/tiny_dnn_out_ctl.md
TINY_DNN_OUT_CTL -- requirements
Module: tiny_dnn_out_ctl

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 s_init  input  1  one-cycle pulse that starts a new pass.
REQ-005 backprop  input  1  pass direction, stable for the whole pass.
REQ-006 k_fin  input  1  one-cycle pulse: the kernel accumulation is complete and acc is valid.
REQ-007 acc  input  16  signed accumulation result, sampled when k_fin=1.
REQ-008 od  input  4  last output channel index (inclusive).
REQ-009 oh, ow  input  5 each  last output row and column indices (inclusive).
REQ-010 os  input  10  output channel stride in words.
REQ-011 oready  input  1  downstream accepts a word.
REQ-012 ovalid  output  1  odata/oa are valid.
REQ-013 odata  output  16  output word.
REQ-014 oa  output  12  output word address.
REQ-015 out_busy  output  1  backpressure to the execution controller; new kernels are held off while it is 1.
REQ-016 outrf  output  1  the pass is complete: the final output word has been accepted.
REQ-017 ovf  output  1  sticky overflow flag: a result was dropped.

Function
REQ-018 The block SHALL buffer results in a 4-entry FIFO with a 3-bit occupancy count.
REQ-019 Push condition: k_fin=1 and either count<4 or a pop occurs in the same cycle.
REQ-020 The pushed entry SHALL be acc, as modified by REQ-036 and REQ-037.
REQ-021 Pop condition: ovalid=1 and oready=1.
REQ-022 ovalid SHALL equal (count!=0).
REQ-023 odata SHALL be the FIFO head entry.
REQ-024 Latency: a k_fin pulse into an empty FIFO SHALL raise ovalid on the next cycle.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged and preserve entry order.
REQ-026 When k_fin=1, count=4 and there is no pop, the result SHALL be dropped, count SHALL stay 4 and ovf SHALL be set.
REQ-027 out_busy SHALL equal (count>=3). This leaves one free slot for the in-flight kernel.
REQ-028 Output counters ox, oy, oc SHALL advance only on a pop, in this order:
 - ox counts 0..ow;
 - at ox=ow, ox wraps to 0 and oy increments over 0..oh;
 - at oy=oh, oy wraps to 0 and oc increments over 0..od.
REQ-029 oa SHALL be computed as oc*os + oy*(ow+1) + ox, truncated to 12 bits.
REQ-030 A pop with oc=od, oy=oh and ox=ow SHALL:
 - set outrf on the next cycle;
 - hold all three counters at their terminal values.
REQ-031 outrf SHALL stay 1 until the next s_init.
REQ-032 While outrf=1, further pops SHALL NOT change the counters or oa.
REQ-033 An s_init pulse SHALL clear all of the following on the next edge, overriding any same-cycle push or pop:
 - count (the FIFO contents are discarded);
 - ox, oy and oc;
 - outrf and ovf.
REQ-034 If od, oh or ow is 0, the corresponding counter SHALL never advance from 0 (single-iteration loop).

Reset
REQ-035 While rst=0, the block SHALL hold, regardless of clk:
 - count=0, ovalid=0, out_busy=0;
 - ox=oy=oc=0, so oa=0;
 - outrf=0 and ovf=0.
 The FIFO storage is not reset, and odata is don't-care while ovalid=0.

Configuration
REQ-036 When TINY_DNN_OUT_RELU_EN is defined and backprop=0, a negative acc SHALL be stored as 0 and a non-negative acc SHALL be stored unchanged.
REQ-037 When TINY_DNN_OUT_RELU_EN is defined and backprop=1, or when the macro is undefined, acc SHALL be stored unchanged. All timing SHALL be identical with or without the macro.

Verification
REQ-038 Single-result latency:
 - Stimulus: reset; s_init; ow=1, oh=0, od=0, os=4; oready=1; k_fin with acc=0x0012.
 - Response: the next cycle has ovalid=1, odata=0x0012, oa=0.
REQ-039 Pass completion and address sequence:
 - Stimulus: ow=1, oh=1, od=1, os=8; four k_fin pulses with oready=1, then four more.
 - Response: oa sequence 0,1,2,3,8,9,10,11; outrf rises the cycle after the 8th pop and holds until s_init.
REQ-040 Backpressure and overflow:
 - Stimulus: oready=0; five consecutive k_fin pulses.
 - Response: out_busy=1 after the 3rd push; count=4 after the 4th; the 5th is dropped and ovf=1.
 - Then oready=1: exactly four words drain, in order.
REQ-041 Simultaneous push and pop when full:
 - Stimulus: count=4, oready=1, k_fin with acc=0x0055.
 - Response: count stays 4 and ovf stays 0; 0x0055 is the 4th word out.
REQ-042 Mid-pass abort:
 - Stimulus: count=2, ox=1, ovf=1; s_init asserted together with k_fin.
 - Response: next cycle count=0, ovalid=0, oa=0, ovf=0, outrf=0.
 - Separately, rst=0 asserted between clock edges clears all outputs immediately.
REQ-043 ReLU (build with TINY_DNN_OUT_RELU_EN):
 - With backprop=0, acc=0xFFF0 yields odata=0x0000.
 - With backprop=1, acc=0xFFF0 yields odata=0xFFF0.
 - Without the macro, both cases yield 0xFFF0.
